// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage.
// Provides the datapath/register-address widths, zero constants, write-enable and
// reset-level constants, load funct3 encodings and a helper that flags the
// reserved load funct3 values.
package wb_stage_pkg;

  localparam int unsigned RegBus     = 32;  // datapath width
  localparam int unsigned RegAddrBus = 5;   // register address width

  localparam logic [RegBus-1:0]     ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] ZeroReg  = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b0;  // reset is active-low
  localparam logic RstDisable   = 1'b1;

  // Load funct3 encodings
  localparam logic [2:0] LdB  = 3'b000;
  localparam logic [2:0] LdH  = 3'b001;
  localparam logic [2:0] LdW  = 3'b010;
  localparam logic [2:0] LdBu = 3'b100;
  localparam logic [2:0] LdHu = 3'b101;

  // funct3 values 011/110/111 are not loads this core implements.
  function automatic logic ld_type_illegal(input logic [2:0] ldtype);
    return (ldtype == 3'b011) || (ldtype == 3'b110) || (ldtype == 3'b111);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational little-endian load aligner.
// Ports:
//   word_i   : raw 32-bit word from data memory
//   addr_i   : low two bits of the effective address
//   ldtype_i : load funct3
//   data_o   : aligned, sign/zero-extended load value
//   bad_o    : misaligned access or unsupported funct3 (caller gates with is_load)
module wb_stage_load_align
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = RegBus
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      ldtype_i,
  output logic [XLEN-1:0] data_o,
  output logic            bad_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = word_i[7:0];
    case (addr_i)
      2'b00:   ld_byte = word_i[7:0];
      2'b01:   ld_byte = word_i[15:8];
      2'b10:   ld_byte = word_i[23:16];
      default: ld_byte = word_i[31:24];
    endcase
    ld_half = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = ZeroWord[XLEN-1:0];
    case (ldtype_i)
      LdB:     data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      LdH:     data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
      LdW:     data_o = word_i;
      LdBu:    data_o = {{(XLEN-8){1'b0}}, ld_byte};
      LdHu:    data_o = {{(XLEN-16){1'b0}}, ld_half};
      default: data_o = ZeroWord[XLEN-1:0];
    endcase
  end

  always_comb begin
    bad_o = ld_type_illegal(ldtype_i)
          | (((ldtype_i == LdH) || (ldtype_i == LdHu)) & addr_i[0])
          | ((ldtype_i == LdW) & (addr_i != 2'b00));
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back logic.
// Captures the MEM-stage result, aligns load data from the synchronous data
// memory, drives the single regfile write port and counts retired instructions.
// Ports:
//   clk_i, rst_i (sync, active-low)     : clock / reset
//   stall_i, flush_i                    : hold stage / insert bubble (flush wins)
//   mem_valid_i .. mem_ldtype_i         : MEM-stage instruction fields
//   dmem_rdata_i                        : memory word, valid in the first WB cycle
//   we_o, waddr_o, wdata_o              : regfile write port
//   exc_o                               : one-cycle load fault pulse
//   retire_cnt_o                        : retired-instruction count
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN   = RegBus,
  parameter int unsigned REG_AW = RegAddrBus,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_valid_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_waddr_i,
  input  logic [XLEN-1:0]   mem_alu_i,
  input  logic              mem_is_load_i,
  input  logic [2:0]        mem_ldtype_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              we_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              exc_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  logic              valid_q;
  logic              new_q;     // first cycle this instruction sits in WB
  logic              we_q;
  logic [REG_AW-1:0] waddr_q;
  logic [XLEN-1:0]   alu_q;
  logic              is_load_q;
  logic [2:0]        ldtype_q;
  logic [XLEN-1:0]   ld_hold_q;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [CNT_W-1:0]  retire_cnt_d;

  logic [XLEN-1:0] ld_word;
  logic [XLEN-1:0] ld_data;
  logic            ld_bad;
  logic            bad;
  logic            retire;

  // Pipeline register
  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      valid_q   <= 1'b0;
      new_q     <= 1'b0;
      we_q      <= WriteDisable;
      waddr_q   <= ZeroReg[REG_AW-1:0];
      alu_q     <= ZeroWord[XLEN-1:0];
      is_load_q <= 1'b0;
      ldtype_q  <= 3'b000;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      new_q   <= 1'b0;
    end else if (!stall_i) begin
      valid_q   <= mem_valid_i;
      new_q     <= mem_valid_i;
      we_q      <= mem_we_i;
      waddr_q   <= mem_waddr_i;
      alu_q     <= mem_alu_i;
      is_load_q <= mem_is_load_i;
      ldtype_q  <= mem_ldtype_i;
    end else begin
      new_q <= 1'b0;
    end
  end

  // The memory only presents the word in the first WB cycle; keep a copy so a
  // stalled load still shows the right value afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      ld_hold_q <= ZeroWord[XLEN-1:0];
    end else if (new_q && is_load_q) begin
      ld_hold_q <= dmem_rdata_i;
    end
  end

  assign ld_word = new_q ? dmem_rdata_i : ld_hold_q;

  wb_stage_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .word_i  (ld_word),
    .addr_i  (alu_q[1:0]),
    .ldtype_i(ldtype_q),
    .data_o  (ld_data),
    .bad_o   (ld_bad)
  );

  assign bad    = is_load_q & ld_bad;
  assign retire = valid_q & new_q & ~bad;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) begin
      // Natural wrap at 2^CNT_W.
      retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    wdata_o      = is_load_q ? ld_data : alu_q;
    waddr_o      = waddr_q;
    // Gated by new_q so a stalled instruction writes only once.
    we_o         = valid_q & new_q & we_q & (waddr_q != ZeroReg[REG_AW-1:0]) & ~bad;
    exc_o        = valid_q & new_q & bad;
    retire_cnt_o = retire_cnt_q;
  end

endmodule
